// File: rtl/mux_8to1_rr_if.sv
// Valid/ready bundle between the eight lane producers, the round-robin merger
// and the shared output stream.
interface mux_8to1_rr_if #(
   parameter int WIDTH = 8
);
   logic [7:0]         in_valid;
   logic [8*WIDTH-1:0] in_data;
   logic [7:0]         in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [2:0]         out_sel;
   logic               out_ready;

   // The merger itself: consumes lane beats and produces the tagged output stream.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   // Surrounding logic: lane producers plus the downstream consumer.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux_8to1_rr.sv
// Round-robin 8-to-1 merger with a registered, lane-tagged output beat.
// Drain and reload may happen in the same cycle, so the stream runs gap-free.
module mux_8to1_rr #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   mux_8to1_rr_if.slave bus
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data_q, data_nxt;
   logic [2:0]       sel_q, sel_nxt;
   logic [2:0]       ptr, ptr_nxt;

   logic             load_en;
   logic             grant_valid;
   logic [2:0]       grant_idx;
   logic [WIDTH-1:0] grant_data;

   // State and holding registers; reset discards any held beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= EMPTY;
         data_q <= '0;
         sel_q  <= '0;
         ptr    <= '0;
      end else begin
         state  <= state_nxt;
         data_q <= data_nxt;
         sel_q  <= sel_nxt;
         ptr    <= ptr_nxt;
      end
   end

   // Search from ptr upward with wrap; the first valid lane wins.
   always_comb begin
      logic [2:0] idx;
      grant_valid = 1'b0;
      grant_idx   = 3'd0;
      grant_data  = '0;
      idx         = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = ptr + 3'(i);
         if (!grant_valid && bus.in_valid[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
      for (int k = 0; k < 8; k++) begin
         if (grant_idx == 3'(k)) grant_data = bus.in_data[k*WIDTH +: WIDTH];
      end
   end

   assign load_en = (state == EMPTY) || bus.out_ready;

   // Next-state: load on grant (replacing any beat being drained), else drain or hold.
   always_comb begin
      state_nxt = state;
      data_nxt  = data_q;
      sel_nxt   = sel_q;
      ptr_nxt   = ptr;
      if (load_en && grant_valid) begin
         state_nxt = FULL;
         data_nxt  = grant_data;
         sel_nxt   = grant_idx;
         ptr_nxt   = grant_idx + 3'd1;
      end else if (state == FULL && bus.out_ready) begin
         state_nxt = EMPTY;
      end
   end

   always_comb begin
      bus.out_valid = (state == FULL);
      bus.out_data  = data_q;
      bus.out_sel   = sel_q;
      bus.in_ready  = (rst_n && load_en && grant_valid) ? (8'b1 << grant_idx) : 8'h00;
   end

endmodule
